rgbw_frame_ctrl: RTL and testbench

- Scheduler between the serial-bit-to-word assembler and the RGBW serial output engine.
- Captures each 32-bit R/G/B/status word on its strobe and buffers it in a small FIFO.
- Converts RGB to RGBW, using W = min(R,G,B) and subtracting W from each colour.
- Hands words to the output engine with a valid/ready handshake, and sequences the end-of-frame latch period after every stream reset.

---
 rtl/rgbw_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_rgbw_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbw_frame_ctrl.sv
// Frame scheduler between the bit-to-word assembler and the RGBW output engine:
// captures strobed words into a FIFO, converts RGB to RGBW and sequences frame latching.
module rgbw_frame_ctrl #(
  parameter int FIFO_AW    = 4,
  parameter int LATCH_CLKS = 5280,
  parameter int LATCH_W    = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_word,
  input  logic        in_strobe,
  output logic [31:0] tx_word,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        tx_idle,
  output logic        tx_latch,
  output logic [15:0] frame_count,
  output logic        fifo_overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  logic               strobe_q;
  logic               pend_vld;
  logic [24:0]        pend_ent;
  logic [24:0]        mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [2:0]         state;
  logic [24:0]        cur_ent;
  logic [LATCH_W-1:0] latch_cnt;
  logic [7:0]         g_in, r_in, b_in, w_min;
  logic               unused_in_bits;

  // Bits 29:24 of the assembler word carry nothing this block needs.
  assign unused_in_bits = ^in_word[29:24];

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push       = pend_vld && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= 1'b0;
      pend_vld <= 1'b0;
      pend_ent <= '0;
    end else begin
      strobe_q <= in_strobe;
      pend_vld <= in_strobe && !strobe_q && in_word[31];
      pend_ent <= in_word[30] ? {1'b1, 24'h0} : {1'b0, in_word[23:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pend_vld && fifo_full) fifo_overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; emptiness comes from the pointers, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= pend_ent;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    g_in  = cur_ent[7:0];
    r_in  = cur_ent[15:8];
    b_in  = cur_ent[23:16];
    w_min = g_in;
    if (r_in < w_min) w_min = r_in;
    if (b_in < w_min) w_min = b_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_ent     <= '0;
      tx_word     <= '0;
      tx_valid    <= 1'b0;
      tx_latch    <= 1'b0;
      latch_cnt   <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_ent <= mem[rd_ptr[FIFO_AW-1:0]];
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          if (cur_ent[24]) begin
            state <= S_DRAIN;
          end else begin
            tx_word  <= {g_in - w_min, r_in - w_min, b_in - w_min, w_min};
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // Latch only once the engine has shifted out every accepted pixel.
          if (tx_idle) begin
            latch_cnt <= LATCH_W'(LATCH_CLKS - 1);
            tx_latch  <= 1'b1;
            state     <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (latch_cnt == '0) begin
            tx_latch    <= 1'b0;
            frame_count <= frame_count + 16'd1;
            state       <= S_IDLE;
          end else begin
            latch_cnt <= latch_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgbw_frame_ctrl.sv
// Self-checking bench for rgbw_frame_ctrl: directed scenarios plus randomized pixels
// compared against a queue-based model of the RGBW conversion and frame sequencing.
module tb_rgbw_frame_ctrl;

  localparam int LATCH_CLKS = 5280;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_word;
  logic        in_strobe;
  logic [31:0] tx_word;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_idle;
  logic        tx_latch;
  logic [15:0] frame_count;
  logic        fifo_overflow;

  int total = 0;
  int bad   = 0;
  int ready_mode;           // 0 = hold low, 1 = hold high, 2 = random
  logic [31:0] exp_q [$];   // words the engine must receive, in order

  rgbw_frame_ctrl #(.FIFO_AW(4), .LATCH_CLKS(LATCH_CLKS), .LATCH_W(13)) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_strobe(in_strobe),
    .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_idle(tx_idle),
    .tx_latch(tx_latch), .frame_count(frame_count), .fifo_overflow(fifo_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected engine word for a pixel: subtract the smallest colour from all three.
  function automatic logic [31:0] rgbw(input logic [23:0] d);
    int c[3];
    int w;
    c[0] = int'(d[7:0]);    // G
    c[1] = int'(d[15:8]);   // R
    c[2] = int'(d[23:16]);  // B
    w = 255;
    foreach (c[i]) if (c[i] < w) w = c[i];
    return {8'(c[0] - w), 8'(c[1] - w), 8'(c[2] - w), 8'(w)};
  endfunction

  function automatic logic [23:0] rand_pixel();
    logic [7:0] shared;
    logic [7:0] b[3];
    shared = 8'($urandom);
    foreach (b[i]) begin
      case ($urandom_range(0, 3))
        0: b[i] = 8'h00;
        1: b[i] = 8'hFF;
        2: b[i] = shared;
        default: b[i] = 8'($urandom);
      endcase
    end
    return {b[2], b[1], b[0]};
  endfunction

  // One clock: starts and ends at a falling edge; scores any handshake on the rising edge.
  task automatic tick();
    logic        acc;
    logic [31:0] wd;
    case (ready_mode)
      0: tx_ready = 1'b0;
      1: tx_ready = 1'b1;
      default: tx_ready = 1'($urandom);
    endcase
    acc = tx_valid && tx_ready;
    wd  = tx_word;
    @(posedge clk);
    #1;
    if (acc) begin
      check("word_was_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("tx_word", wd, exp_q.pop_front());
    end
    check("valid_latch_excl", 32'(tx_valid & tx_latch), 32'd0);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit keep);
    in_word   = w;
    in_strobe = 1'b1;
    if (keep && w[31] && !w[30]) exp_q.push_back(rgbw(w[23:0]));
    tick();
    tick();
    in_strobe = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while (exp_q.size() > 0 && g < budget) begin
      tick();
      g++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic measure_latch(input logic [15:0] exp_fc);
    int n = 0;
    int g = 0;
    while (!tx_latch && g < 100) begin
      tick();
      g++;
    end
    check("latch_seen", 32'(tx_latch), 32'd1);
    while (tx_latch && n < 6000) begin
      tick();
      n++;
    end
    check("latch_len", 32'(n), 32'(LATCH_CLKS));
    check("frame_count", 32'(frame_count), 32'(exp_fc));
  endtask

  initial begin
    rst        = 1'b1;
    in_word    = '0;
    in_strobe  = 1'b0;
    tx_ready   = 1'b0;
    tx_idle    = 1'b0;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("rst_tx_word", tx_word, 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_latch", 32'(tx_latch), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_overflow", 32'(fifo_overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Single pixel: latency of three edges, then held until accepted.
    in_word   = 32'h80FF8040;
    in_strobe = 1'b1;
    exp_q.push_back(rgbw(24'hFF8040));
    tick();
    check("lat_edge0", 32'(tx_valid), 32'd0);
    tick();
    in_strobe = 1'b0;
    check("lat_edge1", 32'(tx_valid), 32'd0);
    tick();
    check("lat_edge2", 32'(tx_valid), 32'd0);
    tick();
    check("lat_edge3", 32'(tx_valid), 32'd1);
    check("single_word", tx_word, 32'h0040BF40);
    repeat (6) begin
      tick();
      check("single_hold_valid", 32'(tx_valid), 32'd1);
      check("single_hold_word", tx_word, 32'h0040BF40);
    end
    ready_mode = 1;
    tick();
    check("single_valid_drop", 32'(tx_valid), 32'd0);
    check("single_delivered", 32'(exp_q.size()), 32'd0);

    // Backpressure: three pixels, engine stalled for 20 clocks.
    ready_mode = 0;
    for (int i = 0; i < 3; i++) send_word({8'h80, rand_pixel()}, 1'b1);
    repeat (20) begin
      tick();
      check("bp_valid", 32'(tx_valid), 32'd1);
      check("bp_stable", tx_word, exp_q[0]);
    end
    ready_mode = 1;
    drain(100);

    // Frame end: two pixels then a marker whose data bits must never reach the engine.
    send_word({8'h80, rand_pixel()}, 1'b1);
    send_word({8'h80, rand_pixel()}, 1'b1);
    send_word({8'hC0, 24'($urandom)}, 1'b1);
    drain(100);
    repeat (10) begin
      tick();
      check("drain_no_latch", 32'(tx_latch), 32'd0);
    end
    tx_idle = 1'b1;
    tick();
    check("latch_starts_next", 32'(tx_latch), 32'd1);
    measure_latch(16'd1);
    tx_idle = 1'b0;

    // Randomized pixels against a randomly stalling engine.
    ready_mode = 2;
    for (int i = 0; i < 24; i++) send_word({8'h80, rand_pixel()}, 1'b1);
    drain(400);
    check("rand_no_overflow", 32'(fifo_overflow), 32'd0);

    // Overflow: one word parks in the output stage, 16 fill the FIFO, the next is dropped.
    ready_mode = 0;
    for (int i = 0; i < 18; i++) begin
      send_word({8'h80, rand_pixel()}, i < 17);
      if (i == 16) check("ovf_not_yet", 32'(fifo_overflow), 32'd0);
      if (i == 17) check("ovf_set", 32'(fifo_overflow), 32'd1);
    end
    ready_mode = 1;
    drain(200);
    repeat (20) tick();
    check("ovf_no_extra", 32'(tx_valid), 32'd0);
    check("ovf_sticky", 32'(fifo_overflow), 32'd1);

    // Strobe filtering: a long strobe yields one entry, an invalid word yields none.
    in_word   = {8'h80, rand_pixel()};
    in_strobe = 1'b1;
    exp_q.push_back(rgbw(in_word[23:0]));
    repeat (5) tick();
    in_strobe = 1'b0;
    repeat (2) tick();
    send_word({8'h00, rand_pixel()}, 1'b1);
    drain(100);
    repeat (10) tick();
    check("filter_idle", 32'(tx_valid), 32'd0);

    // Marker with no pixels still latches and counts a frame.
    tx_idle = 1'b1;
    send_word(32'hC0000000, 1'b1);
    measure_latch(16'd2);

    // Asynchronous reset in the middle of a latch period, with a pixel queued.
    send_word(32'hC0000000, 1'b1);
    begin
      int g = 0;
      while (!tx_latch && g < 100) begin
        tick();
        g++;
      end
    end
    check("rst_test_latch", 32'(tx_latch), 32'd1);
    repeat (50) tick();
    send_word({8'h80, rand_pixel()}, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("arst_tx_latch", 32'(tx_latch), 32'd0);
    check("arst_tx_valid", 32'(tx_valid), 32'd0);
    check("arst_frame_count", 32'(frame_count), 32'd0);
    check("arst_overflow", 32'(fifo_overflow), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    tx_idle = 1'b0;
    repeat (20) tick();
    check("arst_fifo_empty", 32'(tx_valid), 32'd0);
    check("arst_no_latch", 32'(tx_latch), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
